prog_clock_divider: RTL and testbench
=====================================

// Module: prog_clock_divider
// PURPOSE
//   Synchronous programmable divide-by-N stage ahead of the ripple counter chain.
//   Produces a one-cycle tick every N clk cycles and a divided square wave, div_out.
//   div_out drives the ripple counter's stage-1 clock.
//   N can be reprogrammed at run time; a new value only takes effect on a period
//   boundary, so no output period is ever truncated.
// PARAMETERS
//   WIDTH      8   width of divisor and count
//   RESET_DIV  4   divisor value loaded into the active register at reset
// PORTS
//   clk       in   1      system clock; all state changes on its rising edge
//   Rst       in   1      asynchronous, active-low reset (0 = reset)
//   en        in   1      count enable; 0 freezes the divider
//   load      in   1      1-cycle strobe: capture div_val as the pending divisor
//   div_val   in   WIDTH  requested divisor N (0 = stopped)
//   tick      out  1      registered; high 1 cycle per completed period
//   div_out   out  1      registered divided clock; high for ceil(N/2) of every N cycles
//   count     out  WIDTH  current phase, 0..N-1
//   load_ack  out  1      registered; 1-cycle pulse when a pending divisor becomes active
// BEHAVIOUR
//   Reset (Rst=0, asynchronous, regardless of clk):
//     - act_div=RESET_DIV, pend_valid=0, count=0, tick=0, load_ack=0
//     - div_out = (RESET_DIV!=0)
//   Registers:
//     - act_div: active divisor
//     - pend_div/pend_valid: one-deep pending slot
//   Let N=act_div, H=(N+1)>>1, term = en && N!=0 && count==N-1.
//   Counting (en=1, N>=1):
//     - count <= term ? 0 : count+1
//     - tick <= term (tick is high in the cycle after count shows N-1)
//     - div_out is registered and equals (count<H) for the count held in the same cycle
//     - N=1: count stays 0, tick=1 every cycle, div_out=1
//   Hold (en=0):
//     - count and div_out hold; tick=0
//     - A pending divisor is applied on the next edge (no period in flight).
//   Stopped (N=0):
//     - count=0, tick=0, div_out=0
//     - A pending divisor is applied on the next edge.
//   Load:
//     - load=1 writes div_val into pend_div and sets pend_valid.
//     - A later load before apply overwrites pend_div; last write wins.
//   Apply (pend_valid && (term || en==0 || N==0)):
//     - act_div <= pend_div, count <= 0, pend_valid <= 0
//     - load_ack <= 1 for exactly one cycle
//     - div_out <= (pend_div!=0)
//   Simultaneous load and apply condition:
//     - div_val bypasses the slot and becomes active directly; load_ack pulses.
//   Reset during operation: all state returns to reset values immediately; a
//     pending divisor is discarded.
//   Widths: count is never >= act_div; no arithmetic overflow at N=2^WIDTH-1.
// TESTING
//   1. Reset release, en=1, N=4 -> count 0,1,2,3,0; tick every 4th cycle;
//      div_out pattern 1100.
//   2. load div_val=5 while count=1 of N=4 -> old period completes; then count
//      0..4; div_out 11100; load_ack 1 cycle.
//   3. N=1, then N=0 via load -> tick=1 every cycle; after apply, tick=0, div_out=0,
//      count=0.
//   4. en=0 at count=2 for 3 cycles -> count, div_out frozen; tick=0; resume at 3.
//   5. load div_val=3 on the term cycle of N=6, then load 7 next cycle ->
//      3 active at once; 7 applied at end of the first 3-period.
//   6. Rst low mid-period with pend_valid=1 -> immediate reset values;
//      pending divisor discarded; N=RESET_DIV.

Source files
------------

// File: rtl/prog_clock_divider_if.sv
// ---------------------------------------------------------------------------
// prog_clock_divider_if
//   Signal bundle between the divider and whoever programs and observes it.
//
//   Handshake: load is a one-cycle strobe with no back-pressure. The divider
//   always accepts it: it captures div_val into a one-deep pending slot, or
//   makes it active directly when a period boundary coincides. load_ack
//   pulses for one cycle on the edge where a new divisor becomes active. A
//   second load before that edge replaces the pending value (last write wins).
//
//   Signals
//     en        count enable (0 freezes the divider)
//     load      strobe: capture div_val as the next divisor
//     div_val   requested divisor N (0 = stopped)
//     tick      one-cycle pulse per completed period
//     div_out   divided square wave, high for ceil(N/2) of every N cycles
//     count     current phase, 0..N-1
//     load_ack  one-cycle pulse when a new divisor becomes active
//
//   Modports
//     master  drives en/load/div_val, observes the outputs
//     slave   the divider itself
// ---------------------------------------------------------------------------
interface prog_clock_divider_if #(
    parameter int unsigned WIDTH = 8
);
    logic             en;
    logic             load;
    logic [WIDTH-1:0] div_val;
    logic             tick;
    logic             div_out;
    logic [WIDTH-1:0] count;
    logic             load_ack;

    modport master (
        output en,
        output load,
        output div_val,
        input  tick,
        input  div_out,
        input  count,
        input  load_ack
    );

    modport slave (
        input  en,
        input  load,
        input  div_val,
        output tick,
        output div_out,
        output count,
        output load_ack
    );
endinterface

// File: rtl/prog_clock_divider.sv
// ---------------------------------------------------------------------------
// prog_clock_divider
//   Synchronous programmable divide-by-N stage. It produces a one-cycle tick
//   every N clk cycles and a registered divided square wave (div_out) that
//   clocks the first ripple-counter stage. A new N takes effect only on a
//   period boundary, so no output period is ever cut short.
//
//   Parameters
//     WIDTH      width of divisor and phase counter
//     RESET_DIV  divisor that is active after reset
//
//   Ports
//     clk   system clock, rising edge
//     Rst   asynchronous active-low reset
//     bus   prog_clock_divider_if.slave: en, load, div_val in;
//           tick, div_out, count, load_ack out
// ---------------------------------------------------------------------------
module prog_clock_divider #(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned RESET_DIV = 4
) (
    input  logic                  clk,
    input  logic                  Rst,
    prog_clock_divider_if.slave   bus
);

    localparam logic [WIDTH-1:0] RESET_ACT     = WIDTH'(RESET_DIV);
    localparam logic             RESET_DIV_OUT = (RESET_DIV != 0);

    // Registered state
    logic [WIDTH-1:0] act_div_q,  act_div_d;
    logic [WIDTH-1:0] pend_div_q, pend_div_d;
    logic             pend_valid_q, pend_valid_d;
    logic [WIDTH-1:0] count_q,    count_d;
    logic             tick_q,     tick_d;
    logic             div_out_q,  div_out_d;
    logic             load_ack_q, load_ack_d;

    // Decode of the current cycle
    logic             div_zero;
    logic [WIDTH-1:0] last_phase;
    logic             term;
    logic             boundary;
    logic             apply;
    logic [WIDTH-1:0] apply_div;
    logic [WIDTH-1:0] count_step;
    logic [WIDTH:0]   half;

    assign div_zero   = (act_div_q == '0);
    // Wraps to all-ones when N=0, but term is gated by div_zero then.
    assign last_phase = act_div_q - WIDTH'(1);
    assign term       = bus.en && !div_zero && (count_q == last_phase);

    // No period is in flight when frozen or stopped, so a new divisor may
    // be applied there as well as at the natural end of a period.
    assign boundary   = term || !bus.en || div_zero;

    // A load on a boundary cycle bypasses the pending slot.
    assign apply      = boundary && (bus.load || pend_valid_q);
    assign apply_div  = bus.load ? bus.div_val : pend_div_q;

    // count stays below act_div, so count+1 never overflows WIDTH bits.
    assign count_step = term ? '0 : (count_q + WIDTH'(1));

    // ceil(N/2) with one extra bit so N=2^WIDTH-1 does not overflow.
    assign half       = ({1'b0, act_div_q} + (WIDTH+1)'(1)) >> 1;

    always_comb begin
        act_div_d    = act_div_q;
        pend_div_d   = pend_div_q;
        pend_valid_d = pend_valid_q;
        count_d      = count_q;
        div_out_d    = div_out_q;
        tick_d       = term;
        load_ack_d   = 1'b0;

        if (apply) begin
            act_div_d    = apply_div;
            pend_valid_d = 1'b0;
            count_d      = '0;
            div_out_d    = (apply_div != '0);
            load_ack_d   = 1'b1;
        end else begin
            // Here a load can only arrive mid-period: park it.
            if (bus.load) begin
                pend_div_d   = bus.div_val;
                pend_valid_d = 1'b1;
            end

            if (div_zero) begin
                count_d   = '0;
                div_out_d = 1'b0;
            end else if (bus.en) begin
                count_d   = count_step;
                // div_out tracks the phase it is registered alongside.
                div_out_d = ({1'b0, count_step} < half);
            end
        end
    end

    always_ff @(posedge clk or negedge Rst) begin
        if (!Rst) begin
            act_div_q    <= RESET_ACT;
            pend_div_q   <= '0;
            pend_valid_q <= 1'b0;
            count_q      <= '0;
            tick_q       <= 1'b0;
            div_out_q    <= RESET_DIV_OUT;
            load_ack_q   <= 1'b0;
        end else begin
            act_div_q    <= act_div_d;
            pend_div_q   <= pend_div_d;
            pend_valid_q <= pend_valid_d;
            count_q      <= count_d;
            tick_q       <= tick_d;
            div_out_q    <= div_out_d;
            load_ack_q   <= load_ack_d;
        end
    end

    assign bus.tick     = tick_q;
    assign bus.div_out  = div_out_q;
    assign bus.count    = count_q;
    assign bus.load_ack = load_ack_q;

endmodule

// File: tb/tb_prog_clock_divider.sv
// ---------------------------------------------------------------------------
// tb_prog_clock_divider
//   Directed bench for prog_clock_divider (WIDTH=8, RESET_DIV=4). A table of
//   per-cycle {inputs, expected outputs} records covers counting, reload,
//   freeze, N=1, N=0 and the simultaneous load/boundary bypass. Hand-written
//   sequences cover asynchronous reset with a pending divisor and the
//   N=255 boundary with back-to-back loads.
// ---------------------------------------------------------------------------
module tb_prog_clock_divider;

  localparam int W = 8;

  typedef struct {
    logic         en;
    logic         load;
    logic [W-1:0] div_val;
    logic         tick;
    logic         div_out;
    logic [W-1:0] count;
    logic         load_ack;
  } vec_t;

  logic clk;
  logic rst_n;

  prog_clock_divider_if #(.WIDTH(W)) bus ();

  prog_clock_divider #(.WIDTH(W), .RESET_DIV(4)) dut (
    .clk (clk),
    .Rst (rst_n),
    .bus (bus)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
    $fatal(1, "watchdog expired");
  end

  // ---------------- scoreboard ----------------
  int n_cmp = 0;
  int n_err = 0;
  vec_t vecs[$];
  logic [W-1:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic add(input logic en, input logic load, input logic [W-1:0] dv,
                     input logic tk, input logic dout, input logic [W-1:0] cnt,
                     input logic ack);
    vec_t v;
    v.en = en; v.load = load; v.div_val = dv;
    v.tick = tk; v.div_out = dout; v.count = cnt; v.load_ack = ack;
    vecs.push_back(v);
  endtask

  // ---------------- driver ----------------
  task automatic drive(input logic en, input logic load, input logic [W-1:0] dv);
    bus.en      = en;
    bus.load    = load;
    bus.div_val = dv;
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int edges;
    int max_cnt;
    int highs;
    int acks;
    logic got_tick;
    logic [W-1:0] e;

    //     en ld dv   tick dout cnt ack
    // N=4 from reset: 0,1,2,3,0 / div_out 1100
    add(1, 0, 0,   0, 1, 1, 0);
    add(1, 0, 0,   0, 0, 2, 0);
    add(1, 0, 0,   0, 0, 3, 0);
    add(1, 0, 0,   1, 1, 0, 0);
    add(1, 0, 0,   0, 1, 1, 0);
    // load 5 at count 1: old period finishes, then 0..4 / 11100
    add(1, 1, 5,   0, 0, 2, 0);
    add(1, 0, 0,   0, 0, 3, 0);
    add(1, 0, 0,   1, 1, 0, 1);
    add(1, 0, 0,   0, 1, 1, 0);
    add(1, 0, 0,   0, 1, 2, 0);
    add(1, 0, 0,   0, 0, 3, 0);
    add(1, 0, 0,   0, 0, 4, 0);
    add(1, 0, 0,   1, 1, 0, 0);
    // freeze at count 2 for 3 cycles, resume at 3
    add(1, 0, 0,   0, 1, 1, 0);
    add(1, 0, 0,   0, 1, 2, 0);
    add(0, 0, 0,   0, 1, 2, 0);
    add(0, 0, 0,   0, 1, 2, 0);
    add(0, 0, 0,   0, 1, 2, 0);
    add(1, 0, 0,   0, 0, 3, 0);
    add(1, 0, 0,   0, 0, 4, 0);
    add(1, 0, 0,   1, 1, 0, 0);
    // load 1 while frozen: applied at once; then tick every cycle
    add(0, 1, 1,   0, 1, 0, 1);
    add(1, 0, 0,   1, 1, 0, 0);
    add(1, 0, 0,   1, 1, 0, 0);
    // load 0 on a term cycle: bypass, then stopped
    add(1, 1, 0,   1, 0, 0, 1);
    add(1, 0, 0,   0, 0, 0, 0);
    add(1, 0, 0,   0, 0, 0, 0);
    // load 6 while stopped: applied at once
    add(1, 1, 6,   0, 1, 0, 1);
    add(1, 0, 0,   0, 1, 1, 0);
    add(1, 0, 0,   0, 1, 2, 0);
    add(1, 0, 0,   0, 0, 3, 0);
    add(1, 0, 0,   0, 0, 4, 0);
    add(1, 0, 0,   0, 0, 5, 0);
    // load 3 on term of N=6 (bypass), load 7 next cycle (pending)
    add(1, 1, 3,   1, 1, 0, 1);
    add(1, 1, 7,   0, 1, 1, 0);
    add(1, 0, 0,   0, 0, 2, 0);
    add(1, 0, 0,   1, 1, 0, 1);
    add(1, 0, 0,   0, 1, 1, 0);
    add(1, 0, 0,   0, 1, 2, 0);

    // reset state
    rst_n = 1'b0;
    drive(0, 0, 0);
    #12;
    check("reset_count",    32'(bus.count),    0);
    check("reset_tick",     32'(bus.tick),     0);
    check("reset_load_ack", 32'(bus.load_ack), 0);
    check("reset_div_out",  32'(bus.div_out),  1);
    @(negedge clk);
    rst_n = 1'b1;

    // table
    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].en, vecs[i].load, vecs[i].div_val);
      step();
      check($sformatf("v%0d_tick", i),     32'(bus.tick),     32'(vecs[i].tick));
      check($sformatf("v%0d_div_out", i),  32'(bus.div_out),  32'(vecs[i].div_out));
      check($sformatf("v%0d_count", i),    32'(bus.count),    32'(vecs[i].count));
      check($sformatf("v%0d_load_ack", i), 32'(bus.load_ack), 32'(vecs[i].load_ack));
    end

    // async reset mid-period with a pending divisor (N=7, count 2 -> 3)
    drive(1, 1, 9);
    step();
    check("prerst_count", 32'(bus.count), 3);
    drive(1, 0, 0);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_count",    32'(bus.count),    0);
    check("async_rst_div_out",  32'(bus.div_out),  1);
    check("async_rst_tick",     32'(bus.tick),     0);
    check("async_rst_load_ack", 32'(bus.load_ack), 0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    // RESET_DIV=4 must be active and the parked 9 must be gone
    exp_q.push_back(1); exp_q.push_back(2); exp_q.push_back(3);
    exp_q.push_back(0); exp_q.push_back(1);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      step();
      check("postrst_count",    32'(bus.count),    32'(e));
      check("postrst_tick",     32'(bus.tick),     32'(e == 0));
      check("postrst_load_ack", 32'(bus.load_ack), 0);
    end

    // N=255 boundary, with loads 10 then 2 during the period (2 must win)
    drive(0, 1, 255);
    step();
    check("n255_apply_ack",   32'(bus.load_ack), 1);
    check("n255_apply_count", 32'(bus.count),    0);
    edges = 0; max_cnt = 0; highs = 0; acks = 0; got_tick = 1'b0;
    while (!got_tick && edges < 300) begin
      if (edges == 0)      drive(1, 1, 10);
      else if (edges == 1) drive(1, 1, 2);
      else                 drive(1, 0, 0);
      step();
      edges++;
      if (int'(bus.count) > max_cnt) max_cnt = int'(bus.count);
      if (bus.div_out) highs++;
      if (bus.load_ack) acks++;
      got_tick = bus.tick;
    end
    check("n255_tick_seen",   32'(got_tick), 1);
    check("n255_period",      32'(edges),    255);
    check("n255_max_count",   32'(max_cnt),  254);
    check("n255_high_cycles", 32'(highs),    128);
    check("n255_acks",        32'(acks),     1);
    check("n255_end_count",   32'(bus.count), 0);
    drive(1, 0, 0);
    step();
    check("n2_count_a",   32'(bus.count),   1);
    check("n2_div_out_a", 32'(bus.div_out), 0);
    check("n2_tick_a",    32'(bus.tick),    0);
    step();
    check("n2_count_b",   32'(bus.count),   0);
    check("n2_div_out_b", 32'(bus.div_out), 1);
    check("n2_tick_b",    32'(bus.tick),    1);

    // ---------------- report ----------------
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
